// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : N-bit parallel-in / serial-out serializer with valid/ready
//             input, per-word bit order, shift-enable pacing, back-to-back
//             frames and first/last/done framing strobes.
//  Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
  parameter int   N          = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         lsb_first,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         first_bit,
  output logic         last_bit,
  output logic         done
);

  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          w_accept;
  logic          w_end_frame;
  logic [N-1:0]  w_din_rev;
  logic [N-1:0]  w_din_ord;

  // Bit-reversed copy of din so MSB-first words can always shift out of bit 0
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign w_din_rev[i] = din[N-1-i];
  end

  assign w_din_ord = lsb_first ? din : w_din_rev;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, ready and accept decode; ready also opens on the last-bit tick
  // so a new word can follow without an idle bubble
  always_comb begin
    w_state_nxt = r_state;
    din_ready   = 1'b0;
    w_end_frame = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        din_ready = 1'b1;
      end
      ST_SHIFT: begin
        w_end_frame = shift_en && (r_cnt == c_LAST);
        din_ready   = w_end_frame;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_accept = din_valid && din_ready;
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
    end else if (w_end_frame) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Shift register, bit counter and done strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_end_frame;
      if (w_accept) begin
        r_shreg <= w_din_ord;
        r_cnt   <= '0;
      end else if (w_end_frame) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if ((r_state == ST_SHIFT) && shift_en) begin
        r_shreg <= {1'b0, r_shreg[N-1:1]};
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign sout_valid = (r_state == ST_SHIFT);
  assign sout       = sout_valid ? r_shreg[0] : IDLE_LEVEL;
  assign first_bit  = sout_valid && (r_cnt == '0);
  assign last_bit   = sout_valid && (r_cnt == c_LAST);
  assign done       = r_done;

endmodule
`default_nettype wire
